// File: rtl/trace_arbiter.sv
// Per-source trace FIFOs merged round-robin onto a single tagged trace_buffer write port.
// Latency: 2 cycles from push into an empty FIFO to the trigger pulse; 1 word/cycle aggregate.
// No backpressure: a push into a full, unpopped FIFO is dropped and flagged; TRACE_ARB_DROP_CNT_EN adds drop_cnt.
module trace_arbiter #(
   parameter int NSRC       = 5,
   parameter int Fpay       = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NSRC-1:0]      trigger_in,
   input  logic [NSRC*Fpay-1:0] trace_in,
   output logic                 trigger,
   output logic [Fpay-1:0]      trace,
   output logic [NSRC-1:0]      overflow
`ifdef TRACE_ARB_DROP_CNT_EN
   ,
   output logic [15:0]          drop_cnt
`endif
);

   localparam int SIDw = (NSRC > 1) ? $clog2(NSRC) : 1;
   localparam int PTRw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNTw = $clog2(FIFO_DEPTH + 1);

   logic [Fpay-1:0] mem    [NSRC][FIFO_DEPTH];
   logic [PTRw-1:0] wr_ptr [NSRC];
   logic [PTRw-1:0] rd_ptr [NSRC];
   logic [CNTw-1:0] count  [NSRC];

   logic [NSRC-1:0] empty;
   logic [NSRC-1:0] full;
   logic [NSRC-1:0] push;
   logic [NSRC-1:0] pop;
   logic [NSRC-1:0] drop;

   logic [SIDw-1:0] last_grant;
   logic [SIDw-1:0] gnt_idx;
   logic            gnt_vld;
   logic [Fpay-1:0] gnt_word;
   logic            unused_hi;

   // A full FIFO still accepts a push when it is popped in the same cycle.
   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         empty[i] = (count[i] == '0);
         full[i]  = (count[i] == CNTw'(FIFO_DEPTH));
         push[i]  = trigger_in[i] & (~full[i] | pop[i]);
         drop[i]  = trigger_in[i] & full[i] & ~pop[i];
      end
   end

   // Search starts one past the last winner so every busy source is served within NSRC cycles.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      pop     = '0;
      for (int off = 1; off <= NSRC; off++) begin
         if (!gnt_vld && !empty[(int'(last_grant) + off) % NSRC]) begin
            gnt_vld = 1'b1;
            gnt_idx = SIDw'((int'(last_grant) + off) % NSRC);
         end
      end
      if (gnt_vld) begin
         pop[gnt_idx] = 1'b1;
      end
   end

   assign gnt_word  = mem[gnt_idx][rd_ptr[gnt_idx]];
   assign unused_hi = ^gnt_word[Fpay-1:Fpay-SIDw];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NSRC; i++) begin
            wr_ptr[i]   <= '0;
            rd_ptr[i]   <= '0;
            count[i]    <= '0;
            overflow[i] <= 1'b0;
            for (int d = 0; d < FIFO_DEPTH; d++) begin
               mem[i][d] <= '0;
            end
         end
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (push[i]) begin
               mem[i][wr_ptr[i]] <= trace_in[i*Fpay +: Fpay];
               wr_ptr[i]         <= wr_ptr[i] + 1'b1;
            end
            if (pop[i]) begin
               rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
            count[i] <= count[i] + CNTw'(push[i]) - CNTw'(pop[i]);
            if (drop[i]) begin
               overflow[i] <= 1'b1;
            end
         end
      end
   end

   // Reset value makes source 0 the first winner.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trigger    <= 1'b0;
         trace      <= '0;
         last_grant <= SIDw'(NSRC - 1);
      end else begin
         trigger <= gnt_vld;
         if (gnt_vld) begin
            trace      <= {gnt_idx, gnt_word[Fpay-SIDw-1:0]};
            last_grant <= gnt_idx;
         end
      end
   end

`ifdef TRACE_ARB_DROP_CNT_EN
   logic [16:0] drop_sum;

   always_comb begin
      drop_sum = {1'b0, drop_cnt};
      for (int i = 0; i < NSRC; i++) begin
         drop_sum = drop_sum + 17'(drop[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt <= '0;
      end else begin
         drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed bench for trace_arbiter: vector table for single-word and round-robin cases,
// hand sequences for overflow, full-plus-pop, mid-operation reset and the optional drop counter.
module tb_trace_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [4:0]   trigger_in;
   logic [159:0] trace_in;
   logic         trigger;
   logic [31:0]  trace;
   logic [4:0]   overflow;
`ifdef TRACE_ARB_DROP_CNT_EN
   logic [15:0]  drop_cnt;
`endif

   always #5 clk = ~clk;

   trace_arbiter #(.NSRC(5), .Fpay(32), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .trigger_in (trigger_in),
      .trace_in   (trace_in),
      .trigger    (trigger),
      .trace      (trace),
      .overflow   (overflow)
`ifdef TRACE_ARB_DROP_CNT_EN
      ,
      .drop_cnt   (drop_cnt)
`endif
   );

   typedef struct {
      logic         rst_before;
      logic [4:0]   trig;
      logic [159:0] din;
      logic         exp_trig;
      logic [31:0]  exp_trace;
      logic [4:0]   exp_ovf;
   } vec_t;

   int checks = 0;
   int failures = 0;
   logic [31:0] emitted[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [159:0] pack5(input logic [31:0] a0, input logic [31:0] a1,
                                          input logic [31:0] a2, input logic [31:0] a3,
                                          input logic [31:0] a4);
      return {a4, a3, a2, a1, a0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (trigger === 1'b1) emitted.push_back(trace);
   endtask

   task automatic do_reset();
      trigger_in = '0;
      trace_in   = '0;
      reset      = 1'b1;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      int   n_sid;
      logic [31:0] last_pay;

      vecs[0] = '{1'b1, 5'b00100, pack5(32'h0, 32'h0, 32'h0000_1234, 32'h0, 32'h0), 1'b0, 32'h0, 5'h0};
      vecs[1] = '{1'b0, 5'b00000, 160'h0, 1'b1, 32'h4000_1234, 5'h0};
      vecs[2] = '{1'b0, 5'b00000, 160'h0, 1'b0, 32'h4000_1234, 5'h0};
      vecs[3] = '{1'b1, 5'b11111, pack5(32'hA, 32'hB, 32'hC, 32'hD, 32'hE), 1'b0, 32'h0, 5'h0};
      vecs[4] = '{1'b0, 5'b00000, 160'h0, 1'b1, 32'h0000_000A, 5'h0};
      vecs[5] = '{1'b0, 5'b00000, 160'h0, 1'b1, 32'h2000_000B, 5'h0};
      vecs[6] = '{1'b0, 5'b00000, 160'h0, 1'b1, 32'h4000_000C, 5'h0};
      vecs[7] = '{1'b0, 5'b00000, 160'h0, 1'b1, 32'h6000_000D, 5'h0};
      vecs[8] = '{1'b0, 5'b00000, 160'h0, 1'b1, 32'h8000_000E, 5'h0};
      vecs[9] = '{1'b0, 5'b00000, 160'h0, 1'b0, 32'h8000_000E, 5'h0};

      trigger_in = '0;
      trace_in   = '0;
      reset      = 1'b1;
      #2;
      chk("reset_trigger", trigger, 1'b0);
      chk("reset_trace", trace, 32'h0);
      chk("reset_overflow", overflow, 5'h0);

      // Table: single word latency and round-robin order
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].rst_before) do_reset();
         trigger_in = vecs[i].trig;
         trace_in   = vecs[i].din;
         step();
         chk($sformatf("vec%0d_trigger", i), trigger, vecs[i].exp_trig);
         chk($sformatf("vec%0d_trace", i), trace, vecs[i].exp_trace);
         chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].exp_ovf);
      end

      // Overflow: all sources pulse 6 cycles; source 1 gets popped once during the burst
      do_reset();
      emitted.delete();
      for (int c = 0; c < 6; c++) begin
         trigger_in = 5'b11111;
         trace_in   = pack5(32'h0100 + c, 32'h1100 + c, 32'h2100 + c, 32'h3100 + c, 32'h4100 + c);
         step();
         if (c == 4) chk("ovf_after_c4", overflow, 5'b10000);
      end
      trigger_in = '0;
      repeat (40) step();
      n_sid = 0;
      last_pay = '0;
      foreach (emitted[j]) begin
         if (emitted[j][31:29] == 3'd1) begin
            n_sid++;
            last_pay = emitted[j];
         end
      end
      chk("ovf_src1_count", n_sid, 5);
      chk("ovf_src1_last", last_pay, 32'h2000_1104);
      chk("ovf_total", emitted.size(), 25);
      chk("ovf_sticky", overflow, 5'b11111);

      // Full FIFO 3 granted and pushed in the same cycle
      do_reset();
      emitted.delete();
      for (int c = 0; c < 4; c++) begin
         trigger_in = 5'b01111;
         trace_in   = pack5(32'h0, 32'h0, 32'h0, 32'h3000 + c, 32'h0);
         step();
      end
      trigger_in = 5'b01000;
      trace_in   = pack5(32'h0, 32'h0, 32'h0, 32'h3004, 32'h0);
      step();
      chk("fullpop_overflow", overflow, 5'h0);
      trigger_in = '0;
      repeat (30) step();
      n_sid = 0;
      foreach (emitted[j]) begin
         if (emitted[j][31:29] == 3'd3) begin
            chk($sformatf("fullpop_word%0d", n_sid), emitted[j], 32'h6000_3000 + n_sid);
            n_sid++;
         end
      end
      chk("fullpop_count", n_sid, 5);
      chk("fullpop_overflow_end", overflow, 5'h0);

      // Asynchronous reset mid-operation
      do_reset();
      emitted.delete();
      trigger_in = 5'b11111;
      trace_in   = pack5(32'h11, 32'h22, 32'h33, 32'h44, 32'h55);
      step();
      trigger_in = '0;
      step();
      chk("rst_pre_trigger", trigger, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_trigger", trigger, 1'b0);
      chk("rst_async_trace", trace, 32'h0);
      #2 reset = 1'b0;
      emitted.delete();
      repeat (20) step();
      chk("rst_no_stale", emitted.size(), 0);
      trigger_in = 5'b00001;
      trace_in   = pack5(32'h55, 32'h0, 32'h0, 32'h0, 32'h0);
      step();
      trigger_in = '0;
      step();
      chk("post_rst_trigger", trigger, 1'b1);
      chk("post_rst_trace", trace, 32'h0000_0055);

`ifdef TRACE_ARB_DROP_CNT_EN
      do_reset();
      chk("dc_reset", drop_cnt, 16'h0);
      for (int c = 0; c < 6; c++) begin
         trigger_in = 5'b11111;
         trace_in   = pack5(32'h1, 32'h2, 32'h3, 32'h4, 32'h5);
         step();
      end
      chk("dc_burst", drop_cnt, 16'd5);
      trigger_in = 5'b01110;
      step();
      chk("dc_three", drop_cnt, 16'd8);
      trigger_in = 5'b11111;
      for (int n = 0; n < 20000 && drop_cnt < 16'hFFF0; n++) begin
         step();
         emitted.delete();
      end
      chk("dc_reach", drop_cnt >= 16'hFFF0, 1'b1);
      repeat (10) step();
      chk("dc_saturate", drop_cnt, 16'hFFFF);
      trigger_in = '0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
